// File: rtl/alu_muldiv_pkg.sv
// Shared defs for the execute-stage ALU and iterative mult/div unit.
// Funct encodings follow the MIPS R-type table.
package alu_muldiv_pkg;

   localparam logic [5:0] FUNCT6_SLL   = 6'h00;
   localparam logic [5:0] FUNCT6_SRL   = 6'h02;
   localparam logic [5:0] FUNCT6_SRA   = 6'h03;
   localparam logic [5:0] FUNCT6_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT6_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT6_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT6_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT6_MULT  = 6'h18;
   localparam logic [5:0] FUNCT6_MULTU = 6'h19;
   localparam logic [5:0] FUNCT6_DIV   = 6'h1A;
   localparam logic [5:0] FUNCT6_DIVU  = 6'h1B;
   localparam logic [5:0] FUNCT6_ADD   = 6'h20;
   localparam logic [5:0] FUNCT6_ADDU  = 6'h21;
   localparam logic [5:0] FUNCT6_SUB   = 6'h22;
   localparam logic [5:0] FUNCT6_SUBU  = 6'h23;
   localparam logic [5:0] FUNCT6_AND   = 6'h24;
   localparam logic [5:0] FUNCT6_OR    = 6'h25;
   localparam logic [5:0] FUNCT6_XOR   = 6'h26;
   localparam logic [5:0] FUNCT6_NOR   = 6'h27;
   localparam logic [5:0] FUNCT6_SLT   = 6'h2A;
   localparam logic [5:0] FUNCT6_SLTU  = 6'h2B;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } md_state_t;

   // MULT/MULTU/DIV/DIVU occupy 0x18..0x1B
   function automatic logic is_muldiv(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

   function automatic logic is_mfmt(input logic [5:0] f);
      return f[5:2] == 4'b0100;
   endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider with sign fixup.
// op_i[1] selects divide, op_i[0] selects unsigned.
module muldiv_seq
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);

   md_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] acc_q, mq_q, opb_q, a_q;
   logic             div_q, nq_q, nr_q, bz_q;

   logic             sa, sb;
   logic [WIDTH-1:0] ma, mb;
   logic [WIDTH:0]   sum, r2, diff;
   logic             ge;
   logic [2*WIDTH-1:0] prod;

   assign sa = ~op_i[0] & a_i[WIDTH-1];
   assign sb = ~op_i[0] & b_i[WIDTH-1];
   assign ma = sa ? -a_i : a_i;
   assign mb = sb ? -b_i : b_i;

   assign sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
   assign r2   = {acc_q, mq_q[WIDTH-1]};
   assign ge   = r2 >= {1'b0, opb_q};
   assign diff = r2 - {1'b0, opb_q};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = RUN;
         RUN:  if (cnt_q == '0) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o = state_q != IDLE;
      done_o = state_q == FIX;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         acc_q <= '0;
         mq_q  <= '0;
         opb_q <= '0;
         a_q   <= '0;
         div_q <= 1'b0;
         nq_q  <= 1'b0;
         nr_q  <= 1'b0;
         bz_q  <= 1'b0;
      end else if (state_q == IDLE && start_i) begin
         cnt_q <= CW'(WIDTH - 1);
         acc_q <= '0;
         mq_q  <= ma;
         opb_q <= mb;
         a_q   <= a_i;
         div_q <= op_i[1];
         nq_q  <= sa ^ sb;
         nr_q  <= sa;
         bz_q  <= b_i == '0;
      end else if (state_q == RUN) begin
         cnt_q <= cnt_q - 1'b1;
         if (div_q) begin
            acc_q <= ge ? diff[WIDTH-1:0] : r2[WIDTH-1:0];
            mq_q  <= {mq_q[WIDTH-2:0], ge};
         end else begin
            acc_q <= sum[WIDTH:1];
            mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
         end
      end
   end

   // Magnitude results are signed here; divide-by-zero bypasses the signs
   always_comb begin
      prod = {acc_q, mq_q};
      if (nq_q) prod = -prod;
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
      if (div_q) begin
         lo_o = nq_q ? -mq_q : mq_q;
         hi_o = nr_q ? -acc_q : acc_q;
         if (bz_q) begin
            lo_o = '1;
            hi_o = a_q;
         end
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational op mux, HI/LO state, MF/MT
// handling and the stall contract with the iterative mult/div unit.
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [5:0]       funct_i6,
   input  logic             valid_i,
   output logic [WIDTH-1:0] y_o,
   output logic             zero_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic [SHW-1:0]   sh;
   logic             busy, done, is_md, is_mx, start, mt_ok;

   assign is_md = is_muldiv(funct_i6);
   assign is_mx = is_mfmt(funct_i6);
   assign start = valid_i & is_md & ~busy;
   assign mt_ok = valid_i & ~busy;

   // mult/div always stall: they retire on done_o
   assign stall_o = valid_i & (is_md | (is_mx & busy));

   muldiv_seq #(
      .WIDTH(WIDTH)
   ) u_seq (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start_i(start),
      .op_i   (funct_i6[1:0]),
      .a_i    (a_i),
      .b_i    (b_i),
      .busy_o (busy),
      .done_o (done),
      .hi_o   (res_hi),
      .lo_o   (res_lo)
   );

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (done) begin
         hi_d = res_hi;
         lo_d = res_lo;
      end else if (mt_ok && funct_i6 == FUNCT6_MTHI) begin
         hi_d = a_i;
      end else if (mt_ok && funct_i6 == FUNCT6_MTLO) begin
         lo_d = a_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   assign sh = b_i[SHW-1:0];

   always_comb begin
      y_o = '0;
      unique case (funct_i6)
         FUNCT6_ADD, FUNCT6_ADDU: y_o = a_i + b_i;
         FUNCT6_SUB, FUNCT6_SUBU: y_o = a_i - b_i;
         FUNCT6_AND:  y_o = a_i & b_i;
         FUNCT6_OR:   y_o = a_i | b_i;
         FUNCT6_NOR:  y_o = ~(a_i | b_i);
         FUNCT6_XOR:  y_o = a_i ^ b_i;
         FUNCT6_SLT:
            y_o = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         FUNCT6_SLTU:
            y_o = {{(WIDTH-1){1'b0}}, a_i < b_i};
         FUNCT6_SLL:  y_o = a_i << sh;
         FUNCT6_SRL:  y_o = a_i >> sh;
         FUNCT6_SRA:  y_o = WIDTH'($signed(a_i) >>> sh);
         FUNCT6_MFHI: y_o = hi_q;
         FUNCT6_MFLO: y_o = lo_q;
         default:     y_o = '0;
      endcase
   end

   assign zero_o = y_o == '0;
   assign busy_o = busy;
   assign done_o = done;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;
   import alu_muldiv_pkg::*;

   logic        clk, rst_n, valid;
   logic [31:0] a, b, y, hi, lo;
   logic [5:0]  funct;
   logic        zero, busy, done, stall;
   int          nvec, nerr;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .a_i     (a),
      .b_i     (b),
      .funct_i6(funct),
      .valid_i (valid),
      .y_o     (y),
      .zero_o  (zero),
      .busy_o  (busy),
      .done_o  (done),
      .stall_o (stall),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic md_run(input logic [5:0] f, input logic [31:0] av,
                         input logic [31:0] bv, output int cyc,
                         output logic st);
      @(negedge clk);
      funct = f; a = av; b = bv; valid = 1'b1;
      #1 st = stall;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; funct = FUNCT6_AND;
      cyc = 1;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #1;
      nvec++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         nerr++;
         $display("FAIL reset busy=%b done=%b hi=%h lo=%h want 0",
                  busy, done, hi, lo);
      end
      nvec++;
      if (stall !== 1'b0) begin
         nerr++; $display("FAIL reset_stall got %b want 0", stall);
      end
   endtask

   task automatic test_comb;
      logic [5:0]  f [7];
      logic [31:0] av[7], bv[7], ev[7];
      f[0] = FUNCT6_SRA;  av[0] = 32'h8000_0010; bv[0] = 4;
      ev[0] = 32'hF800_0001;
      f[1] = FUNCT6_SLTU; av[1] = 32'hFFFF_FFFF; bv[1] = 1; ev[1] = 0;
      f[2] = FUNCT6_SLT;  av[2] = 32'hFFFF_FFFF; bv[2] = 1; ev[2] = 1;
      f[3] = FUNCT6_SUB;  av[3] = 5; bv[3] = 5; ev[3] = 0;
      f[4] = FUNCT6_NOR;  av[4] = 32'h0F0F_0000; bv[4] = 32'h0000_00FF;
      ev[4] = 32'hF0F0_FF00;
      f[5] = FUNCT6_ADD;  av[5] = 32'hFFFF_FFFF; bv[5] = 2; ev[5] = 1;
      f[6] = 6'h3F;       av[6] = 32'h1234; bv[6] = 32'h5678; ev[6] = 0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         funct = f[i]; a = av[i]; b = bv[i];
         #1;
         nvec++;
         if (y !== ev[i] || zero !== (ev[i] == 0)) begin
            nerr++;
            $display("FAIL comb[%0d] f=%h y=%h z=%b want %h", i, f[i],
                     y, zero, ev[i]);
         end
      end
   endtask

   task automatic test_mult;
      int cyc; logic st;
      md_run(FUNCT6_MULT, 32'hFFFF_FFFD, 7, cyc, st);
      nvec++;
      if (cyc !== 33 || st !== 1'b1) begin
         nerr++;
         $display("FAIL mult_lat cyc=%0d stall=%b want 33 1", cyc, st);
      end
      nvec++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin
         nerr++;
         $display("FAIL mult hi=%h lo=%h want ffffffff ffffffeb", hi, lo);
      end
      nvec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         nerr++; $display("FAIL mult_idle busy=%b done=%b", busy, done);
      end
      md_run(FUNCT6_MULTU, 32'hFFFF_FFFD, 7, cyc, st);
      nvec++;
      if (hi !== 32'h6 || lo !== 32'hFFFF_FFEB) begin
         nerr++;
         $display("FAIL multu hi=%h lo=%h want 6 ffffffeb", hi, lo);
      end
   endtask

   task automatic test_div;
      int cyc; logic st;
      md_run(FUNCT6_DIV, 32'hFFFF_FFF9, 2, cyc, st);
      nvec++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         nerr++;
         $display("FAIL div hi=%h lo=%h want ffffffff fffffffd", hi, lo);
      end
      md_run(FUNCT6_DIVU, 100, 0, cyc, st);
      nvec++;
      if (cyc !== 33 || hi !== 32'd100 || lo !== 32'hFFFF_FFFF) begin
         nerr++;
         $display("FAIL divu0 cyc=%0d hi=%h lo=%h want 33 64 ffffffff",
                  cyc, hi, lo);
      end
      md_run(FUNCT6_DIV, 32'hFFFF_FFFB, 0, cyc, st);
      nvec++;
      if (hi !== 32'hFFFF_FFFB || lo !== 32'hFFFF_FFFF) begin
         nerr++;
         $display("FAIL div0 hi=%h lo=%h want fffffffb ffffffff", hi, lo);
      end
      md_run(FUNCT6_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, st);
      nvec++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         nerr++;
         $display("FAIL div_ovf hi=%h lo=%h want 0 80000000", hi, lo);
      end
      md_run(FUNCT6_DIVU, 100, 7, cyc, st);
      nvec++;
      if (hi !== 32'd2 || lo !== 32'd14) begin
         nerr++; $display("FAIL divu hi=%h lo=%h want 2 e", hi, lo);
      end
   endtask

   task automatic test_hazard;
      int n; logic ok;
      @(negedge clk);
      funct = FUNCT6_MULT; a = 6; b = 7; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (4) @(negedge clk);
      funct = FUNCT6_MFLO; valid = 1'b1;
      #1;
      ok = 1'b1; n = 0;
      while (!done && n < 40) begin
         if (stall !== 1'b1) ok = 1'b0;
         @(negedge clk);
         #1 n++;
      end
      if (stall !== 1'b1) ok = 1'b0;
      nvec++;
      if (!ok || done !== 1'b1) begin
         nerr++;
         $display("FAIL mflo_stall ok=%b done=%b want 1 1", ok, done);
      end
      @(negedge clk);
      #1;
      nvec++;
      if (stall !== 1'b0 || y !== 32'd42 || zero !== 1'b0) begin
         nerr++;
         $display("FAIL mflo_after stall=%b y=%h want 0 2a", stall, y);
      end
      valid = 1'b0;
   endtask

   task automatic test_mt;
      int cyc; logic st; logic [31:0] h0;
      @(negedge clk);
      funct = FUNCT6_MTHI; a = 32'h1234_5678; valid = 1'b1;
      @(negedge clk);
      funct = FUNCT6_MTLO; a = 32'h0BAD_F00D;
      @(negedge clk);
      funct = FUNCT6_MFHI;
      #1;
      nvec++;
      if (y !== 32'h1234_5678 || stall !== 1'b0) begin
         nerr++; $display("FAIL mthi y=%h want 12345678", y);
      end
      nvec++;
      if (lo !== 32'h0BAD_F00D) begin
         nerr++; $display("FAIL mtlo lo=%h want 0badf00d", lo);
      end
      funct = FUNCT6_MULTU; a = 2; b = 3;
      h0 = hi;
      @(posedge clk);
      @(negedge clk);
      funct = FUNCT6_MTHI; a = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      #1;
      nvec++;
      if (hi !== h0 || stall !== 1'b1) begin
         nerr++;
         $display("FAIL mthi_busy hi=%h stall=%b want %h 1", hi, stall, h0);
      end
      valid = 1'b0;
      cyc = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      @(posedge clk);
      #1;
      nvec++;
      if (hi !== 32'd0 || lo !== 32'd6) begin
         nerr++; $display("FAIL mt_then_mul hi=%h lo=%h want 0 6", hi, lo);
      end
      @(negedge clk);
      funct = FUNCT6_MTHI; a = 32'h0000_ABCD; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic test_reset_mid;
      int cyc; logic st, saw;
      @(negedge clk);
      funct = FUNCT6_DIV; a = 100; b = 7; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      nvec++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         nerr++;
         $display("FAIL rst_mid busy=%b hi=%h lo=%h want 0", busy, hi, lo);
      end
      saw = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (done) saw = 1'b1;
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) saw = 1'b1;
      end
      nvec++;
      if (saw !== 1'b0) begin
         nerr++; $display("FAIL rst_nodone saw=%b want 0", saw);
      end
      md_run(FUNCT6_MULTU, 2, 3, cyc, st);
      nvec++;
      if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd6) begin
         nerr++;
         $display("FAIL rst_multu cyc=%0d hi=%h lo=%h want 33 0 6",
                  cyc, hi, lo);
      end
   endtask

   initial begin
      nvec = 0; nerr = 0;
      rst_n = 1'b0; valid = 1'b0;
      funct = FUNCT6_AND; a = 0; b = 0;
      test_reset;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      test_comb;
      test_mult;
      test_div;
      test_hazard;
      test_mt;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the single-cycle datapath ALU in the MIPS single-cycle core.
- Keeps the combinational R-type ops and adds SRA and SLTU.
- Adds an iterative multiply/divide unit with architectural HI/LO registers and MFHI/MFLO/MTHI/MTLO.
- Sits in the execute stage. The controller uses stall_o to hold the PC while HI/LO results are pending.

Parameters:
- WIDTH, 32: datapath width in bits. Must be even and at least 8.
- SHW, $clog2(WIDTH): shift-amount width (derived, not overridable).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- a_i  in  WIDTH  operand A (rs).
- b_i  in  WIDTH  operand B (rt or immediate).
- funct_i6  in  6  MIPS funct code. Encodings are in the shared defs package.
- valid_i  in  1  instruction in execute is valid this cycle.
- y_o  out  WIDTH  combinational result.
- zero_o  out  1  y_o == 0.
- busy_o  out  1  multiply/divide iteration in progress.
- done_o  out  1  one-cycle pulse when HI/LO are written by a mult/div.
- stall_o  out  1  controller must hold the instruction this cycle.
- hi_o  out  WIDTH  current HI (debug/trace).
- lo_o  out  WIDTH  current LO (debug/trace).

Behaviour:
- Reset (asynchronous on rst_ni low): state=IDLE, HI=LO=0, busy_o=0, done_o=0. Iteration registers are cleared.
- Combinational ops (zero latency, independent of state):
  - ADD/SUB: wrap modulo 2^WIDTH, no overflow trap.
  - AND, OR, NOR, XOR.
  - SLT: signed compare, result 1/0. SLTU: unsigned compare, result 1/0.
  - SLL/SRL/SRA: y = a shifted by b[SHW-1:0]. SRA replicates a[WIDTH-1].
  - Unknown funct: y_o=0. The ALU never outputs x.
- MFHI/MFLO: y_o = HI/LO. If busy_o=1, stall_o=1 instead and y_o is don't-care.
- MTHI/MTLO: write HI/LO on the clock edge when valid_i=1 and busy_o=0. While busy, stall_o=1 and no write.
- MULT/MULTU/DIV/DIVU accept: valid_i=1 and state=IDLE. The op is captured and the unit goes IDLE->RUN. stall_o=1 in the accept cycle, because the instruction retires only when done_o fires.
- Any mult/div/MF/MT op with valid_i=1 while state!=IDLE gives stall_o=1 and is ignored. The same instruction is re-presented by the controller.
- State machine IDLE -> RUN -> FIX -> IDLE:
  - RUN: exactly WIDTH cycles, counter WIDTH-1 down to 0.
  - Multiply: shift-add on operand magnitudes.
  - Divide: restoring, one quotient bit per cycle.
  - FIX: one cycle. Applies signs and writes HI/LO; done_o=1 in that cycle.
  - Total latency from accept edge to done_o: WIDTH+1 cycles.
  - busy_o=1 in RUN and FIX.
- Result placement:
  - Multiply: {HI,LO} = full 2*WIDTH-bit product.
  - Divide: LO = quotient, HI = remainder.
- Signed results:
  - MULT: product negated if sign(a)^sign(b).
  - DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Most-negative / -1: LO = most-negative, HI = 0. No trap.
- Divide by zero, signed or unsigned: full latency still taken. LO = all ones, HI = a (original dividend).
- valid_i dropping mid-operation does not abort. The operation completes and HI/LO are written.
- Reset mid-operation: immediate return to IDLE. HI/LO are cleared and no done_o is issued.
- zero_o always reflects y_o, including MFHI/MFLO results.

Decomposition:
- Shared defs package: add FUNCT6_SRA, FUNCT6_SLTU, FUNCT6_MULT, FUNCT6_MULTU, FUNCT6_DIV, FUNCT6_DIVU, FUNCT6_MFHI, FUNCT6_MTHI, FUNCT6_MFLO, FUNCT6_MTLO.
- Package also holds the md_state_t enum (IDLE, RUN, FIX) and a helper function is_muldiv(funct).
- One sub-module: muldiv_seq. It contains the FSM, counter, iteration registers and sign fixup.
- alu_muldiv holds the combinational op mux, HI/LO, MT writes and stall logic.

Test Plan (WIDTH=32):
- Combinational ops:
  - SRA a=0x80000010, b=4 -> y=0xF8000001.
  - SLTU a=0xFFFFFFFF, b=1 -> y=0. SLT with the same operands -> y=1.
  - SUB 5-5 -> y=0 and zero_o=1.
- MULT a=-3 (0xFFFFFFFD), b=7 -> done_o exactly 33 cycles after accept; HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU with the same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=100, b=0 -> after 33 cycles LO=0xFFFFFFFF, HI=100.
- Busy-hazard check:
  - MFLO issued 5 cycles after MULT accept -> stall_o=1 until done_o.
  - In the cycle after done_o, MFLO gives y_o=new LO and stall_o=0.
  - MTHI while busy -> HI unchanged.
- Reset mid-operation: assert rst_ni=0 mid-RUN (cycle 10 of a DIV) -> busy_o=0 and HI=LO=0 immediately, no done_o. A new MULTU 2*3 after release -> LO=6, HI=0.
